// File: rtl/sram_rw_pkg.sv
// Shared helpers for the SRAM read/write controller: lane count and per-lane even parity.
// Parity helper exists only when SRAM_PARITY_EN is defined.
package sram_rw_pkg;

    function automatic int lanes_of(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

`ifdef SRAM_PARITY_EN
    // Even parity over one lane; callers zero-extend the lane to 64 bits.
    function automatic logic lane_parity(input logic [63:0] lane);
        return ^lane;
    endfunction
`endif

endpackage

// File: rtl/sram_array.sv
// Single-port synchronous-read array with lane write masks; 1-cycle read latency.
// No backpressure: rdata holds its value whenever en=0.
module sram_array #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int LANE_W = 8,
    parameter int LANES  = WIDTH / LANE_W
) (
    input  logic              clock,
    input  logic              en,
    input  logic              wmode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [LANES-1:0]  wmask,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] bit_we;

    // Bits beyond LANES*LANE_W are per-lane side bits (one per lane), masked with their lane.
    for (genvar b = 0; b < WIDTH; b++) begin : g_we
        if (b < LANES * LANE_W) begin : g_data
            assign bit_we[b] = wmask[b / LANE_W];
        end else begin : g_side
            assign bit_we[b] = wmask[b - LANES * LANE_W];
        end
    end

    always_ff @(posedge clock) begin
        if (en) begin
            if (wmode) begin
                mem[addr] <= (mem[addr] & ~bit_we) | (wdata & bit_we);
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_rw_ctrl.sv
// Valid/ready SRAM controller with lane masks and out-of-range errors; read latency 1 cycle.
// A stalled response (rsp_valid && !rsp_ready) drops req_ready and freezes the array. Option: SRAM_PARITY_EN.
module sram_rw_ctrl
    import sram_rw_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    localparam int LANES = lanes_of(DATA_W, LANE_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

`ifdef SRAM_PARITY_EN
    localparam int MEM_W = DATA_W + LANES;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    logic             fire;
    logic             in_range;
    logic             arr_en;
    logic             rsp_valid_q;
    logic             oor_q;
    logic             par_err;
    logic [MEM_W-1:0] arr_wdata;
    logic [MEM_W-1:0] arr_rdata;
    rsp_t             rsp;

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign fire      = req_valid && req_ready;
    assign in_range  = 32'(req_addr) < 32'(DEPTH);
    assign arr_en    = fire && in_range;

`ifdef SRAM_PARITY_EN
    logic [LANES-1:0] wpar;
    logic [LANES-1:0] rpar_err;

    always_comb begin
        wpar     = '0;
        rpar_err = '0;
        for (int i = 0; i < LANES; i++) begin
            wpar[i]     = lane_parity(64'(req_wdata[i*LANE_W +: LANE_W]));
            rpar_err[i] = lane_parity(64'(arr_rdata[i*LANE_W +: LANE_W])) ^ arr_rdata[DATA_W+i];
        end
    end

    assign arr_wdata = {wpar, req_wdata};
    assign par_err   = |rpar_err;
`else
    assign arr_wdata = req_wdata;
    assign par_err   = 1'b0;
`endif

    sram_array #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_array (
        .clock (clock),
        .en    (arr_en),
        .wmode (req_write),
        .addr  (req_addr),
        .wdata (arr_wdata),
        .wmask (req_mask),
        .rdata (arr_rdata)
    );

    // A read accept wins over a response fire so back-to-back reads keep rsp_valid high.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            oor_q       <= 1'b0;
        end else if (fire && !req_write) begin
            rsp_valid_q <= 1'b1;
            oor_q       <= !in_range;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    always_comb begin
        rsp = '0;
        if (rsp_valid_q) begin
            rsp.err = oor_q || par_err;
            if (!oor_q) begin
                rsp.rdata = arr_rdata[DATA_W-1:0];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp.rdata;
    assign rsp_err   = rsp.err;

endmodule
